// File: rtl/rs5_plic.sv
// rtl/rs5_plic.sv - RS5 platform-level interrupt controller
// Level-sensitive gateways, priority/threshold arbitration and claim/complete handshake.
module rs5_plic #(
  parameter int i_cnt = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en_i,
  input  logic [3:0]       we_i,
  input  logic [23:0]      addr_i,
  input  logic [31:0]      data_i,
  output logic [31:0]      data_o,
  input  logic [i_cnt:1]   irq_i,
  input  logic             iack_i,
  output logic [i_cnt:1]   iack_o,
  output logic             irq_o
);

  localparam logic [23:0] PEND_OFS   = 24'h001000;
  localparam logic [23:0] ENABLE_OFS = 24'h002000;
  localparam logic [23:0] THRESH_OFS = 24'h200000;
  localparam logic [23:0] CLAIM_OFS  = 24'h200004;

  logic [2:0]     r_prio [1:i_cnt];
  logic [i_cnt:1] r_pend;
  logic [i_cnt:1] r_en;
  logic [i_cnt:1] r_isvc;
  logic [i_cnt:1] r_iack;
  logic [2:0]     r_thr;
  logic [4:0]     r_claim;
  logic [31:0]    r_rdata;

  logic [23:0]    w_addr;
  logic           w_wr;
  logic           w_rd;
  logic [31:0]    w_wmask;
  logic [31:0]    w_wdata;
  logic           w_sel_prio;
  logic           w_sel_pend;
  logic           w_sel_en;
  logic           w_sel_thr;
  logic           w_sel_claim;
  logic [4:0]     w_cand_id;
  logic [2:0]     w_cand_prio;
  logic           w_cmpl_valid;
  logic [i_cnt:1] w_gate;
  logic [i_cnt:1] w_claim_oh;
  logic [i_cnt:1] w_cmpl_oh;
  logic [31:0]    w_rdata;

  assign w_addr      = addr_i & 24'hFF_FFFC;
  assign w_wr        = en_i & (we_i != 4'b0000);
  assign w_rd        = en_i & (we_i == 4'b0000);
  assign w_wmask     = {{8{we_i[3]}}, {8{we_i[2]}}, {8{we_i[1]}}, {8{we_i[0]}}};
  assign w_wdata     = data_i & w_wmask;

  assign w_sel_prio  = (w_addr[23:7] == 17'd0);
  assign w_sel_pend  = (w_addr == PEND_OFS);
  assign w_sel_en    = (w_addr == ENABLE_OFS);
  assign w_sel_thr   = (w_addr == THRESH_OFS);
  assign w_sel_claim = (w_addr == CLAIM_OFS);

  // Ascending scan with a strict compare keeps the lowest ID on priority ties.
  always_comb begin
    w_cand_id   = 5'd0;
    w_cand_prio = 3'd0;
    for (int k = 1; k <= i_cnt; k++) begin
      if (r_pend[k] && r_en[k] && (r_prio[k] > r_thr) && (r_prio[k] > w_cand_prio)) begin
        w_cand_id   = 5'(k);
        w_cand_prio = r_prio[k];
      end
    end
  end

  assign irq_o = (w_cand_id != 5'd0);

  assign w_cmpl_valid = w_wr && w_sel_claim && (w_wdata != 32'd0) &&
                        (w_wdata <= 32'(i_cnt));

  always_comb begin
    w_claim_oh = '0;
    w_cmpl_oh  = '0;
    for (int k = 1; k <= i_cnt; k++) begin
      w_claim_oh[k] = iack_i && (w_cand_id == 5'(k));
      w_cmpl_oh[k]  = w_cmpl_valid && (w_wdata == 32'(k));
    end
  end

  // A source in service cannot re-arm until it has been completed.
  assign w_gate = irq_i & ~r_pend & ~r_isvc;

  always_comb begin
    w_rdata = 32'd0;
    if (w_sel_prio) begin
      for (int k = 1; k <= i_cnt; k++) begin
        if (w_addr[6:2] == 5'(k)) begin
          w_rdata = {29'd0, r_prio[k]};
        end
      end
    end else if (w_sel_pend) begin
      w_rdata[i_cnt:1] = r_pend;
    end else if (w_sel_en) begin
      w_rdata[i_cnt:1] = r_en;
    end else if (w_sel_thr) begin
      w_rdata = {29'd0, r_thr};
    end else if (w_sel_claim) begin
      w_rdata = {27'd0, r_claim};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 1; k <= i_cnt; k++) begin
        r_prio[k] <= 3'd0;
      end
      r_pend  <= '0;
      r_en    <= '0;
      r_isvc  <= '0;
      r_iack  <= '0;
      r_thr   <= 3'd0;
      r_claim <= 5'd0;
      r_rdata <= 32'd0;
    end else begin
      if (w_wr && w_sel_prio && we_i[0]) begin
        for (int k = 1; k <= i_cnt; k++) begin
          if (w_addr[6:2] == 5'(k)) begin
            r_prio[k] <= data_i[2:0];
          end
        end
      end
      if (w_wr && w_sel_en) begin
        for (int k = 1; k <= i_cnt; k++) begin
          if (w_wmask[k]) begin
            r_en[k] <= data_i[k];
          end
        end
      end
      if (w_wr && w_sel_thr && we_i[0]) begin
        r_thr <= data_i[2:0];
      end

      r_pend <= (r_pend & ~w_claim_oh) | w_gate;
      // Complete is applied before a same-cycle claim.
      r_isvc <= (r_isvc & ~w_cmpl_oh) | w_claim_oh;
      r_iack <= w_claim_oh;

      if (iack_i) begin
        r_claim <= w_cand_id;
      end else if (w_cmpl_valid && (w_wdata[4:0] == r_claim)) begin
        r_claim <= 5'd0;
      end

      if (w_rd) begin
        r_rdata <= w_rdata;
      end
    end
  end

  assign data_o = r_rdata;
  assign iack_o = r_iack;

endmodule

// File: tb/tb_rs5_plic.sv
// tb/tb_rs5_plic.sv - self-checking bench for rs5_plic
// Reference model of sources, arbitration and bus map checked every cycle, plus literal checks.
module tb_rs5_plic;
  localparam int N = 3;
  localparam logic [23:0] A_PEND  = 24'h001000;
  localparam logic [23:0] A_EN    = 24'h002000;
  localparam logic [23:0] A_THR   = 24'h200000;
  localparam logic [23:0] A_CLAIM = 24'h200004;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [3:0]  we = 4'h0;
  logic [23:0] addr = 24'h0;
  logic [31:0] wdata = 32'h0;
  logic [31:0] data_o;
  logic [N:1]  irq = '0;
  logic        iack = 1'b0;
  logic [N:1]  iack_o;
  logic        irq_o;

  int vectors = 0;
  int errs = 0;

  rs5_plic #(.i_cnt(N)) dut (
    .clk(clk), .reset_n(rst_n), .en_i(en), .we_i(we), .addr_i(addr),
    .data_i(wdata), .data_o(data_o), .irq_i(irq), .iack_i(iack),
    .iack_o(iack_o), .irq_o(irq_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  bit [2:0]    m_prio [1:N];
  bit          m_pend [1:N];
  bit          m_en   [1:N];
  bit          m_isvc [1:N];
  int          m_thr;
  int          m_claim;
  logic [31:0] exp_data;
  logic [N:1]  exp_iack;
  logic        exp_irq;
  int          mc;
  bit          mg [1:N];
  logic [31:0] mmask;
  logic [31:0] md;
  logic [23:0] wa;

  // Scan priority levels from the top; first enabled pending ID at a level wins.
  function automatic int model_cand();
    for (int p = 7; p >= 1; p--) begin
      if (p > m_thr) begin
        for (int id = 1; id <= N; id++) begin
          if (m_pend[id] && m_en[id] && int'(m_prio[id]) == p) return id;
        end
      end
    end
    return 0;
  endfunction

  function automatic logic [31:0] model_read(input logic [23:0] a);
    logic [23:0] w;
    logic [31:0] r;
    w = a & 24'hFFFFFC;
    r = 32'd0;
    if (w >= 24'd4 && w <= 24'(4 * N)) r = {29'd0, m_prio[int'(w >> 2)]};
    else if (w == A_PEND) begin
      for (int id = 1; id <= N; id++) r[id] = m_pend[id];
    end else if (w == A_EN) begin
      for (int id = 1; id <= N; id++) r[id] = m_en[id];
    end else if (w == A_THR) r = 32'(m_thr);
    else if (w == A_CLAIM) r = 32'(m_claim);
    return r;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int id = 1; id <= N; id++) begin
        m_prio[id] = 3'd0; m_pend[id] = 1'b0; m_en[id] = 1'b0; m_isvc[id] = 1'b0;
      end
      m_thr = 0; m_claim = 0; exp_data = 32'd0; exp_iack = '0; exp_irq = 1'b0;
    end else begin
      mc = model_cand();
      for (int id = 1; id <= N; id++) mg[id] = irq[id] && !m_pend[id] && !m_isvc[id];
      if (en && we == 4'h0) exp_data = model_read(addr);
      if (en && we != 4'h0) begin
        mmask = {{8{we[3]}}, {8{we[2]}}, {8{we[1]}}, {8{we[0]}}};
        md = wdata & mmask;
        wa = addr & 24'hFFFFFC;
        if (wa >= 24'd4 && wa <= 24'(4 * N) && we[0]) m_prio[int'(wa >> 2)] = md[2:0];
        if (wa == A_EN) begin
          for (int id = 1; id <= N; id++) if (mmask[id]) m_en[id] = md[id];
        end
        if (wa == A_THR && we[0]) m_thr = int'(md[2:0]);
        if (wa == A_CLAIM && md >= 32'd1 && md <= 32'(N)) begin
          m_isvc[int'(md)] = 1'b0;
          if (m_claim == int'(md)) m_claim = 0;
        end
      end
      exp_iack = '0;
      if (iack) begin
        m_claim = mc;
        if (mc != 0) begin
          m_pend[mc] = 1'b0;
          m_isvc[mc] = 1'b1;
          exp_iack[mc] = 1'b1;
        end
      end
      for (int id = 1; id <= N; id++) if (mg[id]) m_pend[id] = 1'b1;
      exp_irq = (model_cand() != 0);
      #1;
      check("irq_o", 32'(irq_o), 32'(exp_irq));
      check("iack_o", 32'(iack_o), 32'(exp_iack));
      check("data_o", data_o, exp_data);
    end
  end

  task automatic bus_wr(input logic [23:0] a, input logic [31:0] d, input logic [3:0] be = 4'hF);
    @(negedge clk); en = 1'b1; we = be; addr = a; wdata = d;
    @(negedge clk); en = 1'b0; we = 4'h0;
  endtask

  task automatic bus_rd(input logic [23:0] a, output logic [31:0] d);
    @(negedge clk); en = 1'b1; we = 4'h0; addr = a;
    @(negedge clk); en = 1'b0; d = data_o;
  endtask

  task automatic pulse_iack();
    @(negedge clk); iack = 1'b1;
    @(negedge clk); iack = 1'b0;
  endtask

  logic [31:0] rd;

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset irq_o", 32'(irq_o), 32'd0);
    check("reset iack_o", 32'(iack_o), 32'd0);
    bus_rd(A_PEND, rd);  check("reset pending", rd, 32'd0);
    bus_rd(A_EN, rd);    check("reset enable", rd, 32'd0);
    bus_rd(A_THR, rd);   check("reset threshold", rd, 32'd0);
    bus_rd(A_CLAIM, rd); check("reset claim", rd, 32'd0);
    pulse_iack();
    check("empty claim iack_o", 32'(iack_o), 32'd0);

    bus_wr(24'h000004, 32'd3);
    bus_wr(A_EN, 32'h2);
    bus_wr(A_THR, 32'd0);
    @(negedge clk); irq = 3'b001;
    @(negedge clk);
    check("irq after set", 32'(irq_o), 32'd1);
    bus_rd(A_PEND, rd); check("pending src1", rd, 32'h2);

    pulse_iack();
    check("iack_o src1", 32'(iack_o), 32'b001);
    check("irq after claim", 32'(irq_o), 32'd0);
    @(negedge clk);
    check("iack_o one cycle", 32'(iack_o), 32'd0);
    bus_rd(A_PEND, rd);  check("pending in service", rd, 32'd0);
    bus_rd(A_CLAIM, rd); check("claim id 1", rd, 32'd1);

    bus_wr(A_CLAIM, 32'd1);
    check("irq right after complete", 32'(irq_o), 32'd0);
    @(negedge clk);
    check("irq re-pend", 32'(irq_o), 32'd1);
    pulse_iack();
    irq = 3'b000;
    bus_wr(A_CLAIM, 32'd1);
    repeat (2) @(negedge clk);
    check("irq stays low", 32'(irq_o), 32'd0);

    irq = 3'b001;
    @(negedge clk);
    check("irq prio3 thr0", 32'(irq_o), 32'd1);
    bus_wr(A_THR, 32'd3);
    check("irq masked by thr", 32'(irq_o), 32'd0);
    bus_wr(24'h000004, 32'd4);
    check("irq prio above thr", 32'(irq_o), 32'd1);
    pulse_iack();
    irq = 3'b000;
    bus_wr(A_CLAIM, 32'd1);

    bus_wr(A_THR, 32'd0);
    bus_wr(24'h000004, 32'd2);
    bus_wr(24'h000008, 32'd2);
    bus_wr(A_EN, 32'h6);
    @(negedge clk); irq = 3'b011;
    @(negedge clk); irq = 3'b000;
    check("irq tie", 32'(irq_o), 32'd1);
    pulse_iack();
    check("tie lowest id", 32'(iack_o), 32'b001);
    bus_rd(A_CLAIM, rd); check("claim tie", rd, 32'd1);
    bus_wr(A_CLAIM, 32'd1);
    pulse_iack();
    check("second claim", 32'(iack_o), 32'b010);
    bus_wr(A_CLAIM, 32'd4);
    bus_wr(A_CLAIM, 32'd0);
    bus_rd(A_CLAIM, rd); check("bad complete ignored", rd, 32'd2);
    bus_wr(A_CLAIM, 32'd2);
    bus_rd(A_CLAIM, rd); check("claim cleared", rd, 32'd0);

    bus_wr(24'h000100, 32'hFFFF_FFFF);
    bus_rd(24'h000100, rd); check("unmapped read", rd, 32'd0);
    bus_rd(24'h000008, rd); check("prio2 intact", rd, 32'd2);
    bus_rd(24'h000000, rd); check("prio id0", rd, 32'd0);

    bus_wr(24'h00000C, 32'd5);
    bus_wr(A_EN, 32'hE);
    bus_wr(A_EN, 32'h0, 4'b0010);
    bus_rd(A_EN, rd); check("byte lane enable", rd, 32'hE);
    @(negedge clk); irq = 3'b110;
    @(negedge clk); irq = 3'b000;
    pulse_iack();
    check("higher prio wins", 32'(iack_o), 32'b100);
    bus_wr(A_CLAIM, 32'd3);
    pulse_iack();
    check("next prio", 32'(iack_o), 32'b010);
    bus_wr(A_CLAIM, 32'd2);
    repeat (2) @(negedge clk);
    check("idle irq", 32'(irq_o), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule

// File: doc/rs5_plic.md
Name: rs5_plic

Overview:
- Platform-level interrupt controller for the RS5 SoC. It sits on the data bus at the PLIC window (address nibble [31:28] in 3..7) with a 24-bit local offset.
- It gathers `i_cnt` level-sensitive peripheral interrupt lines and applies per-source priority, enable and a global threshold.
- It drives the core's machine external interrupt (`irq_o`, routed to mip.MEIP, bit 11 of `irq_i` on the core).
- It converts the core's interrupt acknowledge into a claim and a one-cycle per-source acknowledge back to the peripheral.

Parameters:
- `i_cnt`, default 1: number of interrupt sources, IDs 1..`i_cnt`. Legal range 1..31; ID 0 means "no interrupt".

Ports:
- `clk`, input, 1: system clock; all state updates on the rising edge.
- `reset_n`, input, 1: asynchronous, active-low reset.
- `en_i`, input, 1: bus select for this block, valid in the current cycle.
- `we_i`, input, 4: byte write enables. All zero means a read.
- `addr_i`, input, 24: byte offset within the PLIC window. Word aligned; bits [1:0] are ignored.
- `data_i`, input, 32: write data.
- `data_o`, output, 32: registered read data.
- `irq_i`, input, [`i_cnt`:1]: level-sensitive source interrupt lines.
- `iack_i`, input, 1: one-cycle interrupt acknowledge pulse from the core.
- `iack_o`, output, [`i_cnt`:1]: one-cycle per-source acknowledge to the peripherals.
- `irq_o`, output, 1: external interrupt request to the core.

Behaviour:
- Reset: all priority, enable, pending and in-service bits, the threshold, the claimed-ID register, `data_o`, `iack_o` and `irq_o` go to 0.
- Register map (offset, access):
  - 0x000000 + 4*id: priority[id], read/write, 3 bits [2:0]; upper bits read 0. Offset 0x000000 itself (id 0) reads 0.
  - 0x001000: pending, read-only. Bit id = pending[id]; bit 0 = 0.
  - 0x002000: enable, read/write. Bit id = enable[id]; bit 0 is hardwired to 0.
  - 0x200000: threshold, read/write, 3 bits.
  - 0x200004: claim/complete. A read returns the claimed ID (0 if none). A write of ID n completes source n.
- Bus writes: take effect at the clock edge where `en_i`=1 and `we_i`≠0. Byte lanes honoured. Writes to read-only or unmapped offsets are ignored.
- Bus reads: `data_o` is registered. It holds the addressed value on the cycle after `en_i`=1 with `we_i`=0. Unmapped offsets return 0. `data_o` is held otherwise.
- Gateway: pending[id] is set on the edge where `irq_i[id]`=1, pending[id]=0 and in_service[id]=0.
  - No new pending is taken while a source is in service.
- Candidate source: the pending, enabled source with priority > threshold and priority ≠ 0.
  - Highest priority wins; on a tie the lowest ID wins.
- `irq_o`: combinational, 1 whenever a candidate exists. It falls in the same cycle the candidate disappears.
- Claim on `iack_i`=1:
  - The current candidate ID is latched into the claimed-ID register.
  - Its pending bit is cleared and its in_service bit is set.
  - `iack_o[id]` pulses high for exactly the next cycle.
  - If no candidate exists, the claimed ID becomes 0 and no `iack_o` bit pulses.
- Complete: writing ID n to 0x200004 clears in_service[n].
  - If n equals the claimed ID, the claimed-ID register returns to 0.
  - An ID of 0 or greater than `i_cnt` is ignored.
  - If `irq_i[n]` is still high, pending[n] re-sets on the following edge.
- Simultaneous events:
  - Claim and a gateway set for different IDs in the same cycle both apply.
  - Complete and claim in the same cycle: the complete is applied first, then the claim.
  - A priority, enable or threshold write updates `irq_o` from the next cycle.

Test Plan:
- Reset → `irq_o`=0, `iack_o`=0. Reads of 0x001000, 0x002000, 0x200000 and 0x200004 each return 0 one cycle after the request.
- Write priority[1]=3, enable=0x2, threshold=0, then raise `irq_i[1]`=1 → pending reads 0x2 and `irq_o`=1 one cycle after the set.
- With that state, pulse `iack_i` → `iack_o[1]`=1 for one cycle, `irq_o`=0, pending reads 0, claim read returns 1.
- Keep `irq_i[1]` high and write 1 to 0x200004 → pending re-sets and `irq_o`=1 again. With `irq_i[1]` low instead, `irq_o` stays 0.
- Write threshold=3 with priority[1]=3 pending → `irq_o`=0. Write priority[1]=4 → `irq_o`=1.
- With `i_cnt`=2 and priority[1]=priority[2]=2, both pending and enabled, pulse `iack_i` → ID 1 claimed first. A second `iack_i` after completing 1 claims ID 2. Write to 0x000100 (unmapped) → no effect; read returns 0.
